// File: rtl/sram_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl_pkg
// Brief    : Shared types and default constants for the SRAM data-memory
//            controller.
// Revision : 1.0
// ============================================================================
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_BASE_ADDR     = 32'd1024;
  localparam int unsigned DEF_SRAM_ADDR_W   = 18;
  localparam int unsigned DEF_ACCESS_CYCLES = 2;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_ACCESS_CYCLES);

endpackage
`default_nettype wire

// File: rtl/sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl
// Brief    : Splits 32-bit MEM-stage loads/stores into two half-word phases
//            on an asynchronous 16-bit SRAM; ready low freezes the pipeline.
// Revision : 1.0
// ============================================================================
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR     = DEF_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W   = DEF_SRAM_ADDR_W,
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  localparam int unsigned ACC_CNT_W = cnt_width(ACCESS_CYCLES);
  localparam logic [ACC_CNT_W-1:0] CNT_LAST = ACC_CNT_W'(ACCESS_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [ACC_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   is_wr_q, is_wr_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]            sram_dq_out_q, sram_dq_out_d;
  logic                   sram_dq_oe_q, sram_dq_oe_d;
  logic                   sram_we_n_q, sram_we_n_d;

  logic                   phase_end;
  logic [31:0]            byte_offset;
  logic                   unused_offset_bits;

  // State register: every flop in the block lives here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      is_wr_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  assign phase_end = (cnt_q == CNT_LAST);

  // Next-state logic; read halves are captured on the last cycle of a phase.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          is_wr_d = wr_en;
          addr_d  = address;
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (phase_end) begin
          if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = ST_HI;
        end else begin
          cnt_d = cnt_q + ACC_CNT_W'(1);
        end
      end
      ST_HI: begin
        if (phase_end) begin
          if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ACC_CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign byte_offset        = addr_d - BASE_ADDR;
  assign unused_offset_bits = &{1'b0, byte_offset[1:0], byte_offset[31:SRAM_ADDR_W]};

  // SRAM pins are registered from the next state so they line up with it.
  always_comb begin
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    case (state_d)
      ST_LO: begin
        sram_addr_d = {byte_offset[SRAM_ADDR_W:2], 1'b0};
        if (is_wr_d) begin
          sram_dq_out_d = wdata_d[15:0];
          sram_dq_oe_d  = 1'b1;
          sram_we_n_d   = 1'b0;
        end
      end
      ST_HI: begin
        sram_addr_d = {byte_offset[SRAM_ADDR_W:2], 1'b1};
        if (is_wr_d) begin
          sram_dq_out_d = wdata_d[31:16];
          sram_dq_oe_d  = 1'b1;
          sram_we_n_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready = ((state_q == ST_IDLE) && !rd_en && !wr_en) || (state_q == ST_DONE);
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_mem_ctrl
// Brief    : Scoreboard bench for sram_mem_ctrl with an async SRAM model.
// Revision : 1.0
// ============================================================================
module tb_sram_mem_ctrl;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  sram_mem_ctrl #(
    .BASE_ADDR    (1024),
    .SRAM_ADDR_W  (18),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model: combinational read, write while we_n is low.
  logic [15:0] mem [0:262143];
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 16'h1234;
      mem[1] <= 16'hABCD;
    end else if (sram_we_n === 1'b0) begin
      mem[sram_addr] <= sram_dq_out;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } done_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  done_t done_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write-beat monitor: every cycle with we_n low must match the next expected beat.
  wr_t wr_exp;
  always @(negedge clk) begin
    if (sram_we_n === 1'b0) begin
      if (wr_q.size() == 0) begin
        check(1'b0, "unexpected_write", {46'd0, sram_addr}, 64'd0);
      end else begin
        wr_exp = wr_q.pop_front();
        check(sram_addr == wr_exp.addr && sram_dq_out == wr_exp.data &&
              sram_dq_oe === 1'b1 && cyc == wr_exp.cyc, "write_beat",
              {14'd0, sram_addr, sram_dq_out, 1'b0, sram_dq_oe, 14'(cyc)},
              {14'd0, wr_exp.addr, wr_exp.data, 2'b01, 14'(wr_exp.cyc)});
      end
    end
  end

  // Completion monitor: a rising edge on ready marks an access finishing.
  bit    prev_ready = 1'b1;
  done_t done_exp;
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b1;
    end else begin
      if (ready === 1'b1 && !prev_ready) begin
        if (done_q.size() == 0) begin
          check(1'b0, "unexpected_done", {32'd0, read_data}, 64'd0);
        end else begin
          done_exp = done_q.pop_front();
          check(read_data == done_exp.rdata, "read_data", {32'd0, read_data}, {32'd0, done_exp.rdata});
          check(cyc == done_exp.cyc, "done_cycle", 64'(cyc), 64'(done_exp.cyc));
        end
      end
      prev_ready = (ready === 1'b1);
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((done_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check(1'b0, "timeout", 64'(done_q.size() + wr_q.size()), 64'd0);
  endtask

  // Issue one request from an IDLE cycle; called right after a posedge.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [17:0] lo_addr, input logic [31:0] exp_rd);
    int c = cyc;
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = wdata;
    done_q.push_back('{exp_rd, c + 2 * AC + 1});
    if (wr) begin
      for (int h = 0; h < 2; h++)
        for (int j = 0; j < AC; j++)
          wr_q.push_back('{lo_addr + 18'(h), (h == 1) ? wdata[31:16] : wdata[15:0], c + 1 + h * AC + j});
    end
    @(posedge clk); #1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = 32'hFFFF_FFFF;
    write_data = 32'h0;
    wait_drain();
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    check(ready === 1'b1, "rst_ready", 64'(ready), 64'd1);
    check(read_data === 32'd0, "rst_read_data", {32'd0, read_data}, 64'd0);
    check(sram_we_n === 1'b1, "rst_we_n", 64'(sram_we_n), 64'd1);
    check(sram_dq_oe === 1'b0, "rst_dq_oe", 64'(sram_dq_oe), 64'd0);
    check(sram_addr === 18'd0, "rst_sram_addr", {46'd0, sram_addr}, 64'd0);
    check(sram_dq_out === 16'd0, "rst_dq_out", {48'd0, sram_dq_out}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Load from BASE_ADDR: halves 0x1234 / 0xABCD.
    issue(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 32'hABCD_1234);
    // Both enables: write wins, read_data untouched.
    issue(1'b1, 1'b1, 32'd1028, 32'h1357_9BDF, 18'd2, 32'hABCD_1234);
    // Plain store at 1032 -> SRAM words 4 and 5.
    issue(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 18'd4, 32'hABCD_1234);

    // Back-to-back loads with rd_en held across DONE.
    c = cyc;
    rd_en   = 1'b1;
    address = 32'd1024;
    done_q.push_back('{32'hABCD_1234, c + 5});
    done_q.push_back('{32'h1357_9BDF, c + 11});
    repeat (5) @(posedge clk);
    #1;
    address = 32'd1028;
    @(posedge clk); #1;
    check(ready === 1'b0, "b2b_ready_low", 64'(ready), 64'd0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    wait_drain();

    // Below BASE_ADDR: word index wraps to 0x3FFFFFFF.
    issue(1'b0, 1'b1, 32'd1020, 32'hCAFE_F00D, 18'h3FFFE, 32'h1357_9BDF);
    issue(1'b1, 1'b0, 32'd1020, 32'd0, 18'h3FFFE, 32'hCAFE_F00D);

    // Reset during the low phase of a store aborts it.
    c = cyc;
    wr_en      = 1'b1;
    address    = 32'd1032;
    write_data = 32'h55AA_6699;
    wr_q.push_back('{18'd4, 16'h6699, c + 1});
    @(posedge clk); #1;
    wr_en = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    check(sram_we_n === 1'b1, "abort_we_n", 64'(sram_we_n), 64'd1);
    check(sram_dq_oe === 1'b0, "abort_dq_oe", 64'(sram_dq_oe), 64'd0);
    check(read_data === 32'd0, "abort_read_data", {32'd0, read_data}, 64'd0);
    check(ready === 1'b1, "abort_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check(ready === 1'b1, "idle_ready", 64'(ready), 64'd1);
    check(wr_q.size() == 0, "write_queue_empty", 64'(wr_q.size()), 64'd0);
    check(done_q.size() == 0, "done_queue_empty", 64'(done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
